keypad_cmd_queue: RTL and testbench

Downstream consumer of the keypad decoder's 3-bit `DecodeOut` code.
- Filters the decoder's scan glitches: the code drops to 3'b111 for about 8 cycles at each column step.
- Debounces the filtered code and turns presses into discrete key-command events, with optional auto-repeat while a key is held.
- Buffers the events in a 4-entry FIFO with a valid/ready handshake, so game/control logic consumes commands at its own pace without losing presses.

---
 rtl/keypad_cmd_queue.sv | 139 +++++++++++++
 tb/tb_keypad_cmd_queue.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_cmd_queue.sv
// ============================================================================
//  Module      : keypad_cmd_queue
//  Description : Glitch-filtering debouncer for the keypad decoder code, with
//                press/auto-repeat event generation and a 4-entry command FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_cmd_queue #(
   parameter int STABLE_CYCLES = 1024,
   parameter int REPEAT_CYCLES = 25_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] KeyCode,
   input  logic       CmdReady,
   input  logic       OvfClr,
   output logic       CmdValid,
   output logic [2:0] CmdCode,
   output logic [2:0] Held,
   output logic [2:0] Level,
   output logic       Overflow
);

   localparam int              CNT_W    = $clog2(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam int              REP_W    = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
   localparam logic [REP_W-1:0] REP_LAST = (REPEAT_CYCLES > 0) ? REP_W'(REPEAT_CYCLES - 1) : '0;
   localparam logic [2:0]       NO_KEY   = 3'b111;

   logic [2:0]       norm;
   logic [2:0]       cand_q, cand_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       held_q, held_d;
   logic [REP_W-1:0] rep_q, rep_d;
   logic             push, push_ok, pop, full, drop;
   logic [3:0][2:0]  mem_q, mem_d;
   logic [1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [2:0]       count_q, count_d;
   logic             ovf_q, ovf_d;

   always_comb begin
      norm   = (KeyCode <= 3'b100) ? KeyCode : NO_KEY;
      cand_d = cand_q;
      cnt_d  = cnt_q;
      held_d = held_q;
      if (norm != cand_q) begin
         cand_d = norm;
         cnt_d  = '0;
      end else if (cnt_q < CNT_LAST) begin
         cnt_d = cnt_q + 1'b1;
      end else if (cand_q != held_q) begin
         held_d = cand_q;
      end
   end

   // A change of Held restarts the repeat timer, so repeat and press pushes are exclusive.
   always_comb begin
      push  = 1'b0;
      rep_d = rep_q;
      if (held_d != held_q) begin
         rep_d = '0;
         push  = (held_d != NO_KEY);
      end else if ((held_q != NO_KEY) && (REPEAT_CYCLES != 0)) begin
         if (rep_q == REP_LAST) begin
            rep_d = '0;
            push  = 1'b1;
         end else begin
            rep_d = rep_q + 1'b1;
         end
      end else begin
         rep_d = '0;
      end
   end

   always_comb begin
      full     = (count_q == 3'd4);
      pop      = (count_q != 3'd0) && CmdReady;
      push_ok  = push && (!full || pop);
      drop     = push && full && !pop;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = held_d;
         wr_ptr_d        = wr_ptr_q + 2'd1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 2'd1;
      end
      if (push_ok && !pop) begin
         count_d = count_q + 3'd1;
      end else if (pop && !push_ok) begin
         count_d = count_q - 3'd1;
      end
      // Setting wins over a same-cycle clear.
      if (drop) begin
         ovf_d = 1'b1;
      end else if (OvfClr) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cand_q   <= NO_KEY;
         cnt_q    <= '0;
         held_q   <= NO_KEY;
         rep_q    <= '0;
         mem_q    <= {4{NO_KEY}};
         wr_ptr_q <= 2'd0;
         rd_ptr_q <= 2'd0;
         count_q  <= 3'd0;
         ovf_q    <= 1'b0;
      end else begin
         cand_q   <= cand_d;
         cnt_q    <= cnt_d;
         held_q   <= held_d;
         rep_q    <= rep_d;
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   assign CmdValid = (count_q != 3'd0);
   assign CmdCode  = CmdValid ? mem_q[rd_ptr_q] : NO_KEY;
   assign Held     = held_q;
   assign Level    = count_q;
   assign Overflow = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_keypad_cmd_queue.sv
// ============================================================================
//  Module      : tb_keypad_cmd_queue
//  Description : Directed bench for keypad_cmd_queue (STABLE=16, REPEAT=100).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_keypad_cmd_queue;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] KeyCode;
   logic       CmdReady;
   logic       OvfClr;
   logic       CmdValid;
   logic [2:0] CmdCode;
   logic [2:0] Held;
   logic [2:0] Level;
   logic       Overflow;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   keypad_cmd_queue #(
      .STABLE_CYCLES(16),
      .REPEAT_CYCLES(100)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .KeyCode (KeyCode),
      .CmdReady(CmdReady),
      .OvfClr  (OvfClr),
      .CmdValid(CmdValid),
      .CmdCode (CmdCode),
      .Held    (Held),
      .Level   (Level),
      .Overflow(Overflow)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1; KeyCode = 3'b111; CmdReady = 1'b0; OvfClr = 1'b0;
      #1;
      tests++; if (Held !== 3'b111) begin fails++; $display("FAIL reset_held got %b want 111", Held); end
      tests++; if (Level !== 3'd0) begin fails++; $display("FAIL reset_level got %0d want 0", Level); end
      tests++; if (CmdValid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", CmdValid); end
      tests++; if (CmdCode !== 3'b111) begin fails++; $display("FAIL reset_code got %b want 111", CmdCode); end
      tests++; if (Overflow !== 1'b0) begin fails++; $display("FAIL reset_ovf got %b want 0", Overflow); end
      tick; tick;
      rst = 1'b0;
   endtask

   task automatic test_single_press;
      KeyCode = 3'b010;
      for (int c = 0; c < 40; c++) begin
         tick;
         if (c == 15) begin
            tests++; if (Held !== 3'b111) begin fails++; $display("FAIL press_early got %b want 111", Held); end
            tests++; if (CmdValid !== 1'b0) begin fails++; $display("FAIL press_early_valid got %b want 0", CmdValid); end
         end
         if (c == 16) begin
            tests++; if (Held !== 3'b010) begin fails++; $display("FAIL press_held got %b want 010", Held); end
            tests++; if (CmdValid !== 1'b1) begin fails++; $display("FAIL press_valid got %b want 1", CmdValid); end
            tests++; if (CmdCode !== 3'b010) begin fails++; $display("FAIL press_code got %b want 010", CmdCode); end
            tests++; if (Level !== 3'd1) begin fails++; $display("FAIL press_level got %0d want 1", Level); end
         end
      end
      tests++; if (Level !== 3'd1) begin fails++; $display("FAIL press_norepeat got %0d want 1", Level); end
      KeyCode = 3'b111;
      for (int c = 0; c < 17; c++) begin
         tick;
         if (c == 15) begin
            tests++; if (Held !== 3'b010) begin fails++; $display("FAIL release_early got %b want 010", Held); end
         end
         if (c == 16) begin
            tests++; if (Held !== 3'b111) begin fails++; $display("FAIL release_held got %b want 111", Held); end
         end
      end
      CmdReady = 1'b1;
      tick;
      CmdReady = 1'b0;
      tests++; if (Level !== 3'd0) begin fails++; $display("FAIL press_pop_level got %0d want 0", Level); end
      tests++; if (CmdCode !== 3'b111) begin fails++; $display("FAIL press_empty_code got %b want 111", CmdCode); end
   endtask

   task automatic test_scan_glitch;
      int bad = 0;
      for (int c = 0; c < 300; c++) begin
         KeyCode = ((c % 50) >= 42) ? 3'b111 : 3'b001;
         tick;
         if (c >= 16 && Held !== 3'b001) bad++;
         if (c == 16) begin
            tests++; if (Level !== 3'd1) begin fails++; $display("FAIL glitch_push got %0d want 1", Level); end
         end
         if (c == 115) begin
            tests++; if (Level !== 3'd1) begin fails++; $display("FAIL glitch_prerep got %0d want 1", Level); end
         end
         if (c == 116) begin
            tests++; if (Level !== 3'd2) begin fails++; $display("FAIL glitch_rep1 got %0d want 2", Level); end
         end
      end
      tests++; if (bad !== 0) begin fails++; $display("FAIL glitch_held_drops got %0d want 0", bad); end
      tests++; if (Level !== 3'd3) begin fails++; $display("FAIL glitch_level got %0d want 3", Level); end
      KeyCode = 3'b111;
      for (int c = 0; c < 20; c++) tick;
      tests++; if (Held !== 3'b111) begin fails++; $display("FAIL glitch_release got %b want 111", Held); end
      tests++; if (Level !== 3'd3) begin fails++; $display("FAIL glitch_final_level got %0d want 3", Level); end
      CmdReady = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tests++; if (CmdCode !== 3'b001) begin fails++; $display("FAIL glitch_drain%0d got %b want 001", i, CmdCode); end
         tick;
      end
      CmdReady = 1'b0;
      tests++; if (CmdValid !== 1'b0) begin fails++; $display("FAIL glitch_empty got %b want 0", CmdValid); end
   endtask

   task automatic test_overflow;
      for (int c = 0; c <= 516; c++) begin
         KeyCode = (c < 516) ? 3'b100 : 3'b111;
         OvfClr  = (c == 516);
         tick;
         if (c == 315) begin
            tests++; if (Level !== 3'd3) begin fails++; $display("FAIL ovf_l3 got %0d want 3", Level); end
         end
         if (c == 316) begin
            tests++; if (Level !== 3'd4) begin fails++; $display("FAIL ovf_l4 got %0d want 4", Level); end
         end
         if (c == 415) begin
            tests++; if (Overflow !== 1'b0) begin fails++; $display("FAIL ovf_early got %b want 0", Overflow); end
         end
         if (c == 416) begin
            tests++; if (Overflow !== 1'b1) begin fails++; $display("FAIL ovf_set got %b want 1", Overflow); end
            tests++; if (Level !== 3'd4) begin fails++; $display("FAIL ovf_level got %0d want 4", Level); end
         end
         if (c == 516) begin
            tests++; if (Overflow !== 1'b1) begin fails++; $display("FAIL ovf_set_wins got %b want 1", Overflow); end
         end
      end
      OvfClr = 1'b0;
      for (int c = 0; c < 16; c++) tick;
      tests++; if (Held !== 3'b111) begin fails++; $display("FAIL ovf_release got %b want 111", Held); end
      OvfClr = 1'b1;
      tick;
      OvfClr = 1'b0;
      tests++; if (Overflow !== 1'b0) begin fails++; $display("FAIL ovf_clear got %b want 0", Overflow); end
      tests++; if (Level !== 3'd4) begin fails++; $display("FAIL ovf_clear_level got %0d want 4", Level); end
      CmdReady = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tests++; if (CmdValid !== 1'b1 || CmdCode !== 3'b100) begin fails++; $display("FAIL ovf_drain%0d got v=%b %b want v=1 100", i, CmdValid, CmdCode); end
         tick;
      end
      CmdReady = 1'b0;
      tests++; if (CmdValid !== 1'b0) begin fails++; $display("FAIL ovf_empty_valid got %b want 0", CmdValid); end
      tests++; if (CmdCode !== 3'b111) begin fails++; $display("FAIL ovf_empty_code got %b want 111", CmdCode); end
   endtask

   task automatic test_direct_change;
      for (int c = 0; c < 60; c++) begin
         KeyCode = (c < 30) ? 3'b000 : 3'b011;
         tick;
         if (c == 16) begin
            tests++; if (Held !== 3'b000) begin fails++; $display("FAIL dir_first got %b want 000", Held); end
         end
         if (c == 45) begin
            tests++; if (Held !== 3'b000) begin fails++; $display("FAIL dir_early got %b want 000", Held); end
         end
         if (c == 46) begin
            tests++; if (Held !== 3'b011) begin fails++; $display("FAIL dir_second got %b want 011", Held); end
            tests++; if (Level !== 3'd2) begin fails++; $display("FAIL dir_level got %0d want 2", Level); end
         end
      end
      KeyCode = 3'b111;
      for (int c = 0; c < 20; c++) tick;
      tests++; if (Level !== 3'd2) begin fails++; $display("FAIL dir_norepeat got %0d want 2", Level); end
      CmdReady = 1'b1;
      tests++; if (CmdCode !== 3'b000) begin fails++; $display("FAIL dir_head0 got %b want 000", CmdCode); end
      tick;
      tests++; if (CmdCode !== 3'b011) begin fails++; $display("FAIL dir_head1 got %b want 011", CmdCode); end
      tick;
      CmdReady = 1'b0;
      tests++; if (CmdValid !== 1'b0) begin fails++; $display("FAIL dir_empty got %b want 0", CmdValid); end
   endtask

   task automatic test_full_push_pop;
      for (int c = 0; c <= 346; c++) begin
         KeyCode  = (c < 30) ? 3'b000 : 3'b011;
         CmdReady = (c == 346);
         tick;
         if (c == 345) begin
            tests++; if (Level !== 3'd4) begin fails++; $display("FAIL fpp_full got %0d want 4", Level); end
            tests++; if (CmdCode !== 3'b000) begin fails++; $display("FAIL fpp_head got %b want 000", CmdCode); end
         end
         if (c == 346) begin
            tests++; if (Level !== 3'd4) begin fails++; $display("FAIL fpp_level got %0d want 4", Level); end
            tests++; if (Overflow !== 1'b0) begin fails++; $display("FAIL fpp_ovf got %b want 0", Overflow); end
            tests++; if (CmdCode !== 3'b011) begin fails++; $display("FAIL fpp_newhead got %b want 011", CmdCode); end
         end
      end
      CmdReady = 1'b0;
      KeyCode  = 3'b111;
      for (int c = 0; c < 20; c++) tick;
      CmdReady = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tests++; if (CmdValid !== 1'b1 || CmdCode !== 3'b011) begin fails++; $display("FAIL fpp_drain%0d got v=%b %b want v=1 011", i, CmdValid, CmdCode); end
         tick;
      end
      CmdReady = 1'b0;
      tests++; if (CmdValid !== 1'b0) begin fails++; $display("FAIL fpp_empty got %b want 0", CmdValid); end
   endtask

   task automatic test_reset_mid;
      for (int c = 0; c < 55; c++) begin
         KeyCode = (c < 30) ? 3'b100 : ((c < 50) ? 3'b010 : 3'b001);
         tick;
      end
      tests++; if (Level !== 3'd2) begin fails++; $display("FAIL rmid_pre_level got %0d want 2", Level); end
      #2;
      rst = 1'b1;
      #1;
      tests++; if (Held !== 3'b111) begin fails++; $display("FAIL rmid_held got %b want 111", Held); end
      tests++; if (Level !== 3'd0) begin fails++; $display("FAIL rmid_level got %0d want 0", Level); end
      tests++; if (CmdValid !== 1'b0 || CmdCode !== 3'b111) begin fails++; $display("FAIL rmid_fifo got v=%b %b want v=0 111", CmdValid, CmdCode); end
      tests++; if (Overflow !== 1'b0) begin fails++; $display("FAIL rmid_ovf got %b want 0", Overflow); end
      tick; tick;
      rst = 1'b0;
      for (int c = 0; c < 17; c++) begin
         tick;
         if (c == 15) begin
            tests++; if (Held !== 3'b111) begin fails++; $display("FAIL rmid_early got %b want 111", Held); end
         end
         if (c == 16) begin
            tests++; if (Held !== 3'b001) begin fails++; $display("FAIL rmid_accept got %b want 001", Held); end
            tests++; if (Level !== 3'd1) begin fails++; $display("FAIL rmid_push got %0d want 1", Level); end
         end
      end
   endtask

   initial begin
      test_reset;
      test_single_press;
      test_scan_glitch;
      test_overflow;
      test_direct_change;
      test_full_push_pop;
      test_reset_mid;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
